propose_integer_seq: RTL and testbench
======================================

Name: propose_integer_seq

Overview:
Sequential, parametrised integer-variable proposer for the MCMC constraint solver. It generalises the fixed three-clause proposer to NUM_CLAUSES clauses over NUM_VARS variables and processes one clause per cycle. For the selected variable it reduces every clause to a bound, intersects the bounds into an interval [lo,hi], then draws the new value uniformly from that interval using an external random word. It sits between the variable-select/scheduler logic and the assignment register file.

Parameters:
NUM_VARS, 4, number of integer variables
NUM_CLAUSES, 8, number of linear clauses
VAL_W, 8, signed width of a variable value and of a clause bias
RAND_W, 16, width of the random input word
IDX_W, clog2(NUM_VARS) (min 1), variable index width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
in_start  in  1  request a proposal; accepted only in IDLE
in_variable_index  in  IDX_W  variable to re-propose
in_coefficients  in  NUM_CLAUSES*NUM_VARS*2  2-bit coefficient per (clause j, var i) at bit offset 2*(j*NUM_VARS+i)
in_biases  in  NUM_CLAUSES*VAL_W  signed bias b_j per clause
in_assignments_old  in  NUM_VARS*VAL_W  current signed assignments
in_random  in  RAND_W  free-running random word, sampled in SAMPLE
out_busy  out  1  high from accept until out_valid
out_valid  out  1  one-cycle result strobe
out_assignments_new  out  NUM_VARS*VAL_W  old vector with the selected variable replaced
out_new_value  out  VAL_W  proposed value
out_conflict  out  1  interval empty or index invalid; value left unchanged
out_active_count  out  clog2(NUM_CLAUSES+1)  clauses containing the variable

Behaviour:
- Clause j: sum_i c_ji*x_i + b_j <= 0. Coefficient encoding: 2'b00=0, 2'b01=+1, 2'b11=-1, 2'b10 reserved and treated as 0.
- Reduction for variable k: s = b_j + sum_{i!=k} c_ji*x_i, computed at width VAL_W+clog2(NUM_VARS)+1. If c_jk=+1: hi = min(hi, -s). If c_jk=-1: lo = max(lo, s). If c_jk=0: clause inactive, no update.
- Bounds are clamped to [-2^(VAL_W-1), 2^(VAL_W-1)-1].
- Reset (reset_n=0 at a clk edge): state IDLE; out_busy, out_valid and out_conflict are 0; out_new_value, out_assignments_new and out_active_count are 0. Reset asserted mid-operation aborts the run with no out_valid.
- FSM: IDLE -> REDUCE -> SAMPLE -> IDLE.
  - IDLE: in_start=1 registers in_variable_index and in_assignments_old, and sets lo=VMIN, hi=VMAX, clause counter=0, active count=0 and out_busy=1.
  - REDUCE: processes clause[counter] each cycle for exactly NUM_CLAUSES cycles.
  - SAMPLE: for one cycle, computes range = hi-lo+1 (VAL_W+1 bits) and value = lo + ((in_random*range) >> RAND_W). It registers all outputs, pulses out_valid for the following cycle and clears out_busy.
- Latency: start accepted at edge t means out_valid is high during the cycle after edge t+NUM_CLAUSES+1. Outputs hold until the next result or reset.
- in_coefficients and in_biases must be stable while out_busy=1. in_start while busy is ignored. in_start in the out_valid cycle is accepted, which gives back-to-back operation.
- Conflict (lo>hi after all clauses), or in_variable_index >= NUM_VARS: out_conflict=1, out_new_value = the old value (or 0 for an invalid index), out_assignments_new = the old vector, same latency.
- Zero active clauses: sample over the full domain.

Decomposition:
- Package propose_pkg holds:
  - the coefficient encoding constants COEF_ZERO, COEF_POS, COEF_NEG;
  - the FSM state enum;
  - VMIN/VMAX derivation functions;
  - the internal sum width.
- Sub-module clause_bound_reduce (combinational), instantiated once and muxed by the clause counter:
  - inputs: clause coefficient row, bias, assignments, index;
  - outputs: active, is_upper, clamped bound.

Test Plan:
1. NUM_VARS=4, VAL_W=8. Clause0 x0+x1-10<=0, clause1 -x0+2<=0, all others zero; x1=3, k=0, random=0x0000 -> interval [2,7], value 2, active_count 2, conflict 0, valid at t+NUM_CLAUSES+2.
2. Same setup, random=0xFFFF -> value 7. Random=0x8000 -> 2+3 = 5. All other assignment lanes unchanged.
3. Clauses x0-1<=0 and -x0+5<=0, x0 old=9 -> conflict=1, new value 9, vector unchanged.
4. All coefficients for k zero (including 2'b10 reserved), random=0x8000 -> range 256, value 0, active_count 0.
5. Reset asserted at REDUCE cycle 3 -> no out_valid, busy=0, outputs 0. A fresh start then completes normally. in_start pulses while busy are ignored, giving exactly one valid.
6. in_variable_index=5 with NUM_VARS=6 legal vs index 6 with NUM_VARS=6 -> the latter gives conflict=1, value 0. Back-to-back start in the valid cycle gives a second valid exactly NUM_CLAUSES+2 cycles later.

Source files
------------

// File: rtl/propose_pkg.sv
// Shared constants, state encoding and width helpers for the integer proposer.
package propose_pkg;

  localparam logic [1:0] COEF_ZERO = 2'b00;
  localparam logic [1:0] COEF_POS  = 2'b01;
  localparam logic [1:0] COEF_NEG  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_SAMPLE
  } state_t;

  function automatic int vmin(input int val_w);
    return -(1 << (val_w - 1));
  endfunction

  function automatic int vmax(input int val_w);
    return (1 << (val_w - 1)) - 1;
  endfunction

  // Room for a bias plus NUM_VARS-1 signed terms without overflow.
  function automatic int sum_width(input int val_w, input int num_vars);
    return val_w + $clog2(num_vars) + 1;
  endfunction

  function automatic int idx_width(input int num_vars);
    return (num_vars > 1) ? $clog2(num_vars) : 1;
  endfunction

endpackage

// File: rtl/clause_bound_reduce.sv
// Reduces one linear clause to a clamped bound on the selected variable.
module clause_bound_reduce
  import propose_pkg::*;
#(
  parameter int NUM_VARS = 4,
  parameter int VAL_W    = 8,
  parameter int IDX_W    = idx_width(NUM_VARS)
) (
  input  logic [NUM_VARS*2-1:0]     coef_row,
  input  logic [VAL_W-1:0]          bias,
  input  logic [NUM_VARS*VAL_W-1:0] assignments,
  input  logic [IDX_W-1:0]          index,
  output logic                      active,
  output logic                      is_upper,
  output logic [VAL_W-1:0]          bound
);

  localparam int SUM_W = sum_width(VAL_W, NUM_VARS);
  localparam logic signed [SUM_W-1:0] LIM_LO = SUM_W'(vmin(VAL_W));
  localparam logic signed [SUM_W-1:0] LIM_HI = SUM_W'(vmax(VAL_W));

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] x_ext;
  logic signed [SUM_W-1:0] raw;
  logic [1:0]              c_k;

  always_comb begin
    sum   = SUM_W'(signed'(bias));
    x_ext = '0;
    c_k   = COEF_ZERO;
    for (int i = 0; i < NUM_VARS; i++) begin
      x_ext = SUM_W'(signed'(assignments[i*VAL_W +: VAL_W]));
      if (index == IDX_W'(i)) begin
        c_k = coef_row[2*i +: 2];
      end else begin
        case (coef_row[2*i +: 2])
          COEF_POS: sum = sum + x_ext;
          COEF_NEG: sum = sum - x_ext;
          default:  sum = sum;
        endcase
      end
    end
    active   = (c_k == COEF_POS) || (c_k == COEF_NEG);
    is_upper = (c_k == COEF_POS);
    raw      = is_upper ? -sum : sum;
    if (raw < LIM_LO) begin
      raw = LIM_LO;
    end else if (raw > LIM_HI) begin
      raw = LIM_HI;
    end
    bound = raw[VAL_W-1:0];
  end

endmodule

// File: rtl/propose_integer_seq.sv
// Sequential integer proposer: one clause per cycle narrows [lo,hi], then a
// uniform draw from the interval replaces the selected variable.
//
//   state    | meaning
//   S_IDLE   | waiting for in_start; result outputs hold
//   S_REDUCE | intersect bound of clause[cnt], NUM_CLAUSES cycles
//   S_SAMPLE | draw value from [lo,hi] and register the result
module propose_integer_seq
  import propose_pkg::*;
#(
  parameter int NUM_VARS    = 4,
  parameter int NUM_CLAUSES = 8,
  parameter int VAL_W       = 8,
  parameter int RAND_W      = 16,
  parameter int IDX_W       = idx_width(NUM_VARS)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_start,
  input  logic [IDX_W-1:0]                  in_variable_index,
  input  logic [NUM_CLAUSES*NUM_VARS*2-1:0] in_coefficients,
  input  logic [NUM_CLAUSES*VAL_W-1:0]      in_biases,
  input  logic [NUM_VARS*VAL_W-1:0]         in_assignments_old,
  input  logic [RAND_W-1:0]                 in_random,
  output logic                              out_busy,
  output logic                              out_valid,
  output logic [NUM_VARS*VAL_W-1:0]         out_assignments_new,
  output logic [VAL_W-1:0]                  out_new_value,
  output logic                              out_conflict,
  output logic [$clog2(NUM_CLAUSES+1)-1:0]  out_active_count
);

  localparam int CNT_W = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int ACT_W = $clog2(NUM_CLAUSES + 1);
  localparam logic signed [VAL_W-1:0] VMIN = VAL_W'(vmin(VAL_W));
  localparam logic signed [VAL_W-1:0] VMAX = VAL_W'(vmax(VAL_W));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CLAUSES - 1);
  localparam logic [IDX_W:0]   NV   = (IDX_W+1)'(NUM_VARS);
  localparam logic [VAL_W:0]   SPAN_ONE = (VAL_W+1)'(1);
  localparam logic [ACT_W-1:0] ACT_ONE  = ACT_W'(1);

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx_q;
  logic                      idx_ok_q;
  logic [NUM_VARS*VAL_W-1:0] asg_q;
  logic signed [VAL_W-1:0]   lo;
  logic signed [VAL_W-1:0]   hi;
  logic [ACT_W-1:0]          act_cnt;

  logic [NUM_VARS*2-1:0]     row;
  logic [VAL_W-1:0]          row_bias;
  logic                      c_active;
  logic                      c_upper;
  logic signed [VAL_W-1:0]   c_bound;

  assign row      = in_coefficients[cnt*NUM_VARS*2 +: NUM_VARS*2];
  assign row_bias = in_biases[cnt*VAL_W +: VAL_W];

  clause_bound_reduce #(
    .NUM_VARS (NUM_VARS),
    .VAL_W    (VAL_W),
    .IDX_W    (IDX_W)
  ) u_reduce (
    .coef_row    (row),
    .bias        (row_bias),
    .assignments (asg_q),
    .index       (idx_q),
    .active      (c_active),
    .is_upper    (c_upper),
    .bound       (c_bound)
  );

  logic [VAL_W:0]            lo_x;
  logic [VAL_W:0]            hi_x;
  logic [VAL_W:0]            span;
  logic [RAND_W+VAL_W:0]     prod;
  logic [VAL_W-1:0]          draw;
  logic [VAL_W-1:0]          old_val;
  logic [NUM_VARS*VAL_W-1:0] merged;
  logic                      conflict;

  // The offset (rand*span)>>RAND_W is always below span, so the VAL_W-bit
  // wrap of lo+offset lands inside [lo,hi].
  always_comb begin
    lo_x    = {lo[VAL_W-1], lo};
    hi_x    = {hi[VAL_W-1], hi};
    span    = hi_x - lo_x + SPAN_ONE;
    prod    = {{(VAL_W+1){1'b0}}, in_random} * {{RAND_W{1'b0}}, span};
    draw    = lo + prod[RAND_W +: VAL_W];
    old_val = '0;
    merged  = asg_q;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        old_val                  = asg_q[i*VAL_W +: VAL_W];
        merged[i*VAL_W +: VAL_W] = draw;
      end
    end
    conflict = !idx_ok_q || (lo > hi);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      idx_q               <= '0;
      idx_ok_q            <= 1'b0;
      asg_q               <= '0;
      lo                  <= '0;
      hi                  <= '0;
      act_cnt             <= '0;
      out_busy            <= 1'b0;
      out_valid           <= 1'b0;
      out_conflict        <= 1'b0;
      out_new_value       <= '0;
      out_assignments_new <= '0;
      out_active_count    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_start) begin
            idx_q    <= in_variable_index;
            idx_ok_q <= ({1'b0, in_variable_index} < NV);
            asg_q    <= in_assignments_old;
            lo       <= VMIN;
            hi       <= VMAX;
            cnt      <= '0;
            act_cnt  <= '0;
            out_busy <= 1'b1;
            state    <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (c_active) begin
            act_cnt <= act_cnt + ACT_ONE;
            if (c_upper) begin
              if (c_bound < hi) hi <= c_bound;
            end else begin
              if (c_bound > lo) lo <= c_bound;
            end
          end
          if (cnt == LAST) begin
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          out_valid           <= 1'b1;
          out_busy            <= 1'b0;
          out_conflict        <= conflict;
          out_new_value       <= conflict ? old_val : draw;
          out_assignments_new <= conflict ? asg_q : merged;
          out_active_count    <= act_cnt;
          state               <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_propose_integer_seq.sv
// Directed bench for propose_integer_seq: a 4-variable and a 6-variable instance.
module tb_propose_integer_seq;

  localparam int NC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        start4;
  logic [1:0]  idx4;
  logic [63:0] coef4;
  logic [63:0] bias4;
  logic [31:0] old4;
  logic [15:0] rnd4;
  logic        busy4, valid4, conf4;
  logic [31:0] new4;
  logic [7:0]  val4;
  logic [3:0]  act4;

  logic        start6;
  logic [2:0]  idx6;
  logic [95:0] coef6;
  logic [63:0] bias6;
  logic [47:0] old6;
  logic [15:0] rnd6;
  logic        busy6, valid6, conf6;
  logic [47:0] new6;
  logic [7:0]  val6;
  logic [3:0]  act6;

  int vectors = 0;
  int miscompares = 0;

  propose_integer_seq #(.NUM_VARS(4), .NUM_CLAUSES(NC)) dut4 (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_start            (start4),
    .in_variable_index   (idx4),
    .in_coefficients     (coef4),
    .in_biases           (bias4),
    .in_assignments_old  (old4),
    .in_random           (rnd4),
    .out_busy            (busy4),
    .out_valid           (valid4),
    .out_assignments_new (new4),
    .out_new_value       (val4),
    .out_conflict        (conf4),
    .out_active_count    (act4)
  );

  propose_integer_seq #(.NUM_VARS(6), .NUM_CLAUSES(NC)) dut6 (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_start            (start6),
    .in_variable_index   (idx6),
    .in_coefficients     (coef6),
    .in_biases           (bias6),
    .in_assignments_old  (old6),
    .in_random           (rnd6),
    .out_busy            (busy6),
    .out_valid           (valid6),
    .out_assignments_new (new6),
    .out_new_value       (val6),
    .out_conflict        (conf6),
    .out_active_count    (act6)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start; returns negedges from the accept edge to out_valid and busy just after accept.
  task automatic run4(output int lat, output logic b0);
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    b0  = busy4;
    lat = 0;
    while (!valid4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic cfg_basic();
    coef4        = '0;
    coef4[1:0]   = 2'b01;
    coef4[3:2]   = 2'b01;
    coef4[9:8]   = 2'b11;
    bias4        = '0;
    bias4[7:0]   = 8'hF6;
    bias4[15:8]  = 8'h02;
    old4         = 32'hAA55_0304;
    idx4         = 2'd0;
    rnd4         = 16'h0000;
  endtask

  initial begin
    int   lat;
    int   lat2;
    int   seen;
    int   vj;
    logic b0;

    reset_n = 1'b0;
    start4 = 1'b0; idx4 = '0; coef4 = '0; bias4 = '0; old4 = '0; rnd4 = '0;
    start6 = 1'b0; idx6 = '0; coef6 = '0; bias6 = '0; old6 = '0; rnd6 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy4, 0);
    check("rst_valid", valid4, 0);
    check("rst_conflict", conf4, 0);
    check("rst_value", val4, 0);
    check("rst_vector", new4, 0);
    check("rst_active", act4, 0);
    check("rst_busy6", busy6, 0);
    reset_n = 1'b1;

    // interval [2,7], draws at the low end, top end and midpoint
    cfg_basic();
    run4(lat, b0);
    check("t1_latency", lat, NC + 1);
    check("t1_busy_accept", b0, 1);
    check("t1_value", val4, 8'h02);
    check("t1_vector", new4, 32'hAA55_0302);
    check("t1_active", act4, 2);
    check("t1_conflict", conf4, 0);
    check("t1_busy_done", busy4, 0);
    @(negedge clk);
    check("t1_valid_pulse", valid4, 0);
    check("t1_value_hold", val4, 8'h02);

    rnd4 = 16'hFFFF;
    run4(lat, b0);
    check("t2_value_ffff", val4, 8'h07);
    check("t2_vector_ffff", new4, 32'hAA55_0307);
    rnd4 = 16'h8000;
    run4(lat, b0);
    check("t2_value_8000", val4, 8'h05);
    check("t2_vector_8000", new4, 32'hAA55_0305);

    // empty interval: hi=1, lo=5
    coef4       = '0;
    coef4[1:0]  = 2'b01;
    coef4[9:8]  = 2'b11;
    bias4       = '0;
    bias4[7:0]  = 8'hFF;
    bias4[15:8] = 8'h05;
    old4        = 32'hAA55_0309;
    rnd4        = 16'h0000;
    run4(lat, b0);
    check("t3_conflict", conf4, 1);
    check("t3_value", val4, 8'h09);
    check("t3_vector", new4, 32'hAA55_0309);
    check("t3_active", act4, 2);

    // variable 2 appears only with zero / reserved coefficients
    idx4         = 2'd2;
    coef4        = '0;
    coef4[5:4]   = 2'b10;
    coef4[1:0]   = 2'b01;
    coef4[27:26] = 2'b11;
    bias4        = 64'h0102_0304_0506_0708;
    rnd4         = 16'h8000;
    run4(lat, b0);
    check("t4_value", val4, 8'h00);
    check("t4_vector", new4, 32'hAA00_0309);
    check("t4_active", act4, 0);
    check("t4_conflict", conf4, 0);

    // bounds beyond the value range clamp to the full domain
    idx4         = 2'd0;
    coef4        = '0;
    coef4[1:0]   = 2'b01;
    coef4[3:2]   = 2'b01;
    coef4[9:8]   = 2'b11;
    coef4[11:10] = 2'b01;
    bias4        = '0;
    bias4[7:0]   = 8'h81;
    bias4[15:8]  = 8'h9C;
    old4         = 32'h0000_9C00;
    rnd4         = 16'hFFFF;
    run4(lat, b0);
    check("clamp_value", val4, 8'h7F);
    check("clamp_vector", new4, 32'h0000_9C7F);
    check("clamp_active", act4, 2);

    // reset during REDUCE aborts the run
    cfg_basic();
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", busy4, 0);
    check("t5_rst_valid", valid4, 0);
    check("t5_rst_value", val4, 0);
    check("t5_rst_vector", new4, 0);
    check("t5_rst_active", act4, 0);
    check("t5_rst_conflict", conf4, 0);
    reset_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid4) seen++;
    end
    check("t5_no_valid_after_abort", seen, 0);

    // restarts while busy are ignored
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    seen = 0;
    vj = -1;
    for (int j = 1; j <= 30; j++) begin
      start4 = (j == 2) || (j == 5);
      @(negedge clk);
      if (valid4) begin
        seen++;
        vj = j;
      end
    end
    start4 = 1'b0;
    check("t5_single_valid", seen, 1);
    check("t5_valid_cycle", vj, NC + 1);
    check("t5_value", val4, 8'h02);

    // six variables: index 5 is legal, index 6 is not; back-to-back start
    coef6         = '0;
    coef6[11:10]  = 2'b01;
    coef6[23:22]  = 2'b11;
    bias6         = '0;
    bias6[7:0]    = 8'hEC;
    bias6[15:8]   = 8'h0A;
    old6          = 48'h1122_3344_5566;
    idx6          = 3'd5;
    rnd6          = 16'h0000;
    @(negedge clk);
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    lat = 0;
    while (!valid6 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t6_latency", lat, NC + 1);
    check("t6_value", val6, 8'h0A);
    check("t6_vector", new6, 48'h0A22_3344_5566);
    check("t6_active", act6, 2);
    check("t6_conflict", conf6, 0);
    idx6   = 3'd6;
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    lat2 = 1;
    while (!valid6 && lat2 < 40) begin
      @(negedge clk);
      lat2++;
    end
    check("t6_b2b_spacing", lat2, NC + 2);
    check("t6_bad_conflict", conf6, 1);
    check("t6_bad_value", val6, 8'h00);
    check("t6_bad_vector", new6, 48'h1122_3344_5566);
    check("t6_bad_active", act6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
